// File: rtl/pb_event_arbiter_pkg.sv
// Package: pb_event_arbiter_pkg
// Purpose: constants and types shared by the push-button event arbiter, the
//          debouncer bank and the calculator input FSM.
//   PB_N_DEFAULT  default number of push buttons
//   pb_slot_e     encoding of the single-entry output slot (EMPTY / FULL)
//   pb_id_width() width of a button index; never narrower than one bit
package pb_event_arbiter_pkg;

  localparam int PB_N_DEFAULT = 4;

  typedef enum logic {
    PB_SLOT_EMPTY = 1'b0,
    PB_SLOT_FULL  = 1'b1
  } pb_slot_e;

  function automatic int pb_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_event_arbiter_rr_arbiter.sv
// Module: rr_arbiter
// Purpose: combinational round-robin pick. Starting at index ptr and wrapping
//          modulo N, the first set request bit wins.
// Ports:
//   req      in   N  request vector
//   ptr      in   W  index the search starts from (0..N-1)
//   gnt_any  out  1  at least one request is set
//   gnt_idx  out  W  winning index (0 when gnt_any is 0)
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_any,
  output logic [W-1:0] gnt_idx
);

  // Rotate/priority-encode/un-rotate folded into one loop: each candidate
  // index is ptr+i reduced mod N. Walking i downward lets the smallest
  // rotated offset overwrite the others, so it ends up as the winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_any = 1'b1;
        gnt_idx = W'(j);
      end
    end
  end

endmodule

// File: rtl/pb_event_arbiter.sv
// Module: pb_event_arbiter
// Purpose: latches one-cycle press pulses from the debouncers into per-button
//          pending flags and hands them, round-robin, to a single consumer
//          through a one-entry valid/ready output slot. Repeated presses on a
//          still-pending button are merged and flagged on the sticky overflow.
// Ports:
//   clk         in   1     rising-edge clock
//   rst         in   1     synchronous active-high reset
//   pb_posedge  in   N_PB  press pulses, bit i = button i
//   evt_ready   in   1     consumer takes evt_id when evt_valid is also high
//   ovf_clr     in   1     clears overflow (a simultaneous new overflow wins)
//   evt_valid   out  1     evt_id holds a granted event
//   evt_id      out  ID_W  index of the granted button
//   pending     out  N_PB  registered pending flags
//   overflow    out  1     sticky: a press was merged into a pending one
module pb_event_arbiter
  import pb_event_arbiter_pkg::*;
#(
  parameter int N_PB = PB_N_DEFAULT,
  localparam int ID_W = pb_id_width(N_PB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_PB-1:0] pb_posedge,
  input  logic            evt_ready,
  input  logic            ovf_clr,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N_PB-1:0] pending,
  output logic            overflow
);

  pb_slot_e        slot_q, slot_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [N_PB-1:0] pending_q, pending_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            overflow_q, overflow_d;

  logic            gnt_any;
  logic [ID_W-1:0] gnt_idx;
  logic            accept;
  logic            grant;
  logic [N_PB-1:0] clr_mask;

  // Arbitration sees only registered pending; a press arriving this cycle
  // becomes eligible one cycle later.
  rr_arbiter #(
    .N (N_PB),
    .W (ID_W)
  ) u_rr_arbiter (
    .req     (pending_q),
    .ptr     (rr_ptr_q),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    slot_d     = slot_q;
    evt_id_d   = evt_id_q;
    rr_ptr_d   = rr_ptr_q;
    overflow_d = overflow_q;

    accept   = (slot_q == PB_SLOT_FULL) && evt_ready;
    // The slot can be refilled in the same cycle it is accepted, which keeps
    // back-to-back events at one per cycle.
    grant    = ((slot_q == PB_SLOT_EMPTY) || accept) && gnt_any;
    clr_mask = grant ? (N_PB'(1) << gnt_idx) : '0;

    // Set is applied after clear, so a press on the button being granted
    // re-arms it instead of being lost.
    pending_d = (pending_q & ~clr_mask) | pb_posedge;

    if (grant) begin
      slot_d   = PB_SLOT_FULL;
      evt_id_d = gnt_idx;
      rr_ptr_d = (gnt_idx == ID_W'(N_PB - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (accept) begin
      slot_d = PB_SLOT_EMPTY;
    end

    // A press collides only with a pending flag that is not leaving this
    // cycle. A new collision outranks ovf_clr.
    if (|(pb_posedge & pending_q & ~clr_mask)) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      slot_q     <= PB_SLOT_EMPTY;
      evt_id_q   <= '0;
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      evt_id_q   <= evt_id_d;
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid = (slot_q == PB_SLOT_FULL);
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Testbench: tb_pb_event_arbiter
// Directed vectors for pb_event_arbiter with N_PB=4. Inputs change and
// outputs are sampled on the falling edge; each step() advances exactly one
// rising edge. Expected values are worked out by hand in the comments.
module tb_pb_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb_posedge;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic [3:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  pb_event_arbiter #(.N_PB(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_posedge (pb_posedge),
    .evt_ready  (evt_ready),
    .ovf_clr    (ovf_clr),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive pb for one rising edge, then return to idle at the next falling edge.
  task automatic step(input logic [3:0] pb);
    pb_posedge = pb;
    @(negedge clk);
    pb_posedge = '0;
  endtask

  task automatic check_slot(input string tag, input logic v, input logic [1:0] id);
    check({tag, "_valid"}, 32'(evt_valid), 32'(v));
    if (v) check({tag, "_id"}, 32'(evt_id), 32'(id));
  endtask

  initial begin
    rst        = 1'b1;
    pb_posedge = '0;
    evt_ready  = 1'b1;
    ovf_clr    = 1'b0;
    @(negedge clk);
    step(4'b0000);
    step(4'b0000);

    // Reset state
    check("rst_valid",    32'(evt_valid), 32'd0);
    check("rst_id",       32'(evt_id),    32'd0);
    check("rst_pending",  32'(pending),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    rst = 1'b0;

    // 1. Single press on button 2: pending after one edge, event after two.
    step(4'b0100);
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_early_valid", 32'(evt_valid), 32'd0);
    step(4'b0000);
    check_slot("t1_evt", 1'b1, 2'd2);
    check("t1_pending_clr", 32'(pending), 32'h0);
    step(4'b0000);
    check_slot("t1_drain", 1'b0, 2'd0);

    // Return rr_ptr to 0 for the simultaneous test.
    rst = 1'b1;
    step(4'b0000);
    rst = 1'b0;

    // 2. Simultaneous 1011 from rr_ptr=0 -> ids 0,1,3 back to back.
    step(4'b1011);
    check("t2_pending", 32'(pending), 32'hB);
    step(4'b0000);
    check_slot("t2_evt0", 1'b1, 2'd0);
    check("t2_pending0", 32'(pending), 32'hA);
    step(4'b0000);
    check_slot("t2_evt1", 1'b1, 2'd1);
    step(4'b0000);
    check_slot("t2_evt3", 1'b1, 2'd3);
    check("t2_pending3", 32'(pending), 32'h0);
    step(4'b0000);
    check_slot("t2_drain", 1'b0, 2'd0);
    // rr_ptr back at 0: with 1001 pending, 0 must win before 3.
    step(4'b1001);
    step(4'b0000);
    check_slot("t2_ptr0_first", 1'b1, 2'd0);
    step(4'b0000);
    check_slot("t2_ptr0_second", 1'b1, 2'd3);
    step(4'b0000);

    // Move rr_ptr to 1 by granting button 0.
    step(4'b0001);
    step(4'b0000);
    check_slot("t3_setup", 1'b1, 2'd0);
    step(4'b0000);

    // 3. Fairness from rr_ptr=1: buttons 0 and 3 re-pulsed after each grant.
    step(4'b1001);
    step(4'b0000);
    check_slot("t3_g0", 1'b1, 2'd3);
    step(4'b1000);
    check_slot("t3_g1", 1'b1, 2'd0);
    check("t3_pending1", 32'(pending), 32'h8);
    step(4'b0001);
    check_slot("t3_g2", 1'b1, 2'd3);
    step(4'b1000);
    check_slot("t3_g3", 1'b1, 2'd0);
    step(4'b0000);
    check_slot("t3_g4", 1'b1, 2'd3);
    step(4'b0000);
    check_slot("t3_drain", 1'b0, 2'd0);
    check("t3_no_ovf", 32'(overflow), 32'd0);

    // Set wins over clear: press button 1 again on the edge it is granted.
    step(4'b0010);
    step(4'b0010);
    check_slot("sw_evt", 1'b1, 2'd1);
    check("sw_pending", 32'(pending), 32'h2);
    check("sw_no_ovf", 32'(overflow), 32'd0);
    step(4'b0000);
    check_slot("sw_evt_again", 1'b1, 2'd1);
    check("sw_pending_clr", 32'(pending), 32'h0);
    step(4'b0000);
    check_slot("sw_drain", 1'b0, 2'd0);

    // 4. Backpressure: id 1 held while button 0 waits; released by evt_ready.
    evt_ready = 1'b0;
    step(4'b0010);
    step(4'b0000);
    check_slot("t4_load", 1'b1, 2'd1);
    step(4'b0001);
    check_slot("t4_hold0", 1'b1, 2'd1);
    check("t4_pending", 32'(pending), 32'h1);
    step(4'b0000);
    check_slot("t4_hold1", 1'b1, 2'd1);
    evt_ready = 1'b1;
    step(4'b0000);
    check_slot("t4_next", 1'b1, 2'd0);
    step(4'b0000);
    check_slot("t4_drain", 1'b0, 2'd0);

    // 5. Overflow: slot held with id 0, two pulses on button 2 five edges apart.
    evt_ready = 1'b0;
    step(4'b0001);
    step(4'b0000);
    check_slot("t5_hold", 1'b1, 2'd0);
    step(4'b0100);
    check("t5_first_pulse_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step(4'b0000);
    check("t5_gap_ovf", 32'(overflow), 32'd0);
    check("t5_gap_pending", 32'(pending), 32'h4);
    step(4'b0100);
    check("t5_ovf_set", 32'(overflow), 32'd1);
    check("t5_ovf_pending", 32'(pending), 32'h4);
    ovf_clr = 1'b1;
    step(4'b0100);
    check("t5_set_beats_clr", 32'(overflow), 32'd1);
    step(4'b0000);
    check("t5_ovf_clr", 32'(overflow), 32'd0);
    ovf_clr   = 1'b0;
    evt_ready = 1'b1;
    step(4'b0000);
    check_slot("t5_evt2", 1'b1, 2'd2);
    step(4'b0000);
    check_slot("t5_single_evt2", 1'b0, 2'd0);
    step(4'b0000);
    check_slot("t5_still_empty", 1'b0, 2'd0);

    // 6. Reset mid-operation with id 2 held, pending 1110 and overflow set.
    evt_ready = 1'b0;
    step(4'b0100);
    step(4'b0000);
    check_slot("t6_hold", 1'b1, 2'd2);
    step(4'b1110);
    check("t6_pending", 32'(pending), 32'hE);
    step(4'b0010);
    check("t6_ovf", 32'(overflow), 32'd1);
    rst = 1'b1;
    step(4'b0000);
    check("t6_rst_valid",    32'(evt_valid), 32'd0);
    check("t6_rst_id",       32'(evt_id),    32'd0);
    check("t6_rst_pending",  32'(pending),   32'd0);
    check("t6_rst_overflow", 32'(overflow),  32'd0);
    rst       = 1'b0;
    evt_ready = 1'b1;
    // rr_ptr was 3 before reset; after reset button 0 must win over 3.
    step(4'b1001);
    step(4'b0000);
    check_slot("t6_first", 1'b1, 2'd0);
    step(4'b0000);
    check_slot("t6_second", 1'b1, 2'd3);
    step(4'b0000);
    check_slot("t6_drain", 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
